sc_regbank_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for a bank of NREGS CC_REG-style registers sharing one write port.

---
 rtl/sc_regbank_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sc_regbank_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_regbank_arbiter.sv
// Round-robin arbiter for four requesters sharing one register-bank write port.
// It also runs a bank-clear sweep that writes zero to every register.
module sc_regbank_arbiter #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned NREGS      = 8
) (
    input  logic                    SC_REGBANK_ARBITER_CLOCK_50,
    input  logic                    SC_REGBANK_ARBITER_RESET_InLow,
    input  logic [3:0]              SC_REGBANK_ARBITER_req_InBUS,
    input  logic [4*ADDR_WIDTH-1:0] SC_REGBANK_ARBITER_addr_InBUS,
    input  logic [4*DATA_WIDTH-1:0] SC_REGBANK_ARBITER_data_InBUS,
    input  logic                    SC_REGBANK_ARBITER_clear_InHigh,
    output logic                    SC_REGBANK_ARBITER_wren_Out,
    output logic [ADDR_WIDTH-1:0]   SC_REGBANK_ARBITER_addr_OutBUS,
    output logic [DATA_WIDTH-1:0]   SC_REGBANK_ARBITER_data_OutBUS,
    output logic [3:0]              SC_REGBANK_ARBITER_grant_OutBUS,
    output logic [3:0]              SC_REGBANK_ARBITER_ack_OutBUS,
    output logic                    SC_REGBANK_ARBITER_busy_Out
);

    localparam int unsigned CntW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StAck,
        StRelease,
        StClear
    } state_e;

    state_e                r_state, w_state_d;
    logic [1:0]            r_ptr, w_ptr_d;
    logic [1:0]            r_idx, w_idx_d;
    logic [CntW-1:0]       r_cnt, w_cnt_d;
    logic                  r_pend, w_pend_d;
    logic [1:0]            w_pick;

    logic                  r_wren, w_wren_d;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
    logic [DATA_WIDTH-1:0] r_data, w_data_d;
    logic [3:0]            r_grant, w_grant_d;
    logic [3:0]            r_ack, w_ack_d;
    logic                  r_busy, w_busy_d;

    // Descending scan so the requester closest to r_ptr is assigned last and wins.
    always_comb begin
        logic [1:0] v_cand;
        w_pick = r_ptr;
        v_cand = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            v_cand = r_ptr + 2'(k);
            if (SC_REGBANK_ARBITER_req_InBUS[v_cand]) begin
                w_pick = v_cand;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_idx_d   = r_idx;
        w_cnt_d   = r_cnt;
        w_pend_d  = r_pend | SC_REGBANK_ARBITER_clear_InHigh;

        unique case (r_state)
            StIdle: begin
                if (r_pend) begin
                    // A clear arriving on the entry cycle itself still queues one more sweep.
                    w_pend_d  = SC_REGBANK_ARBITER_clear_InHigh;
                    w_cnt_d   = '0;
                    w_state_d = StClear;
                end else if (SC_REGBANK_ARBITER_req_InBUS != 4'b0000) begin
                    w_idx_d   = w_pick;
                    w_state_d = StWrite;
                end
            end
            StWrite:   w_state_d = StAck;
            StAck: begin
                w_ptr_d   = r_idx + 2'd1;
                w_state_d = StRelease;
            end
            StRelease: begin
                if (!SC_REGBANK_ARBITER_req_InBUS[r_idx]) begin
                    w_state_d = StIdle;
                end
            end
            StClear: begin
                if (r_cnt == CntW'(NREGS - 1)) begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            default:   w_state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        w_wren_d  = 1'b0;
        w_addr_d  = '0;
        w_data_d  = '0;
        w_grant_d = 4'b0000;
        w_ack_d   = 4'b0000;
        w_busy_d  = (w_state_d != StIdle);
        unique case (w_state_d)
            StWrite: begin
                w_wren_d  = 1'b1;
                w_addr_d  = SC_REGBANK_ARBITER_addr_InBUS[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                w_data_d  = SC_REGBANK_ARBITER_data_InBUS[w_pick*DATA_WIDTH +: DATA_WIDTH];
                w_grant_d = 4'b0001 << w_idx_d;
            end
            StAck: begin
                w_grant_d = 4'b0001 << w_idx_d;
                w_ack_d   = 4'b0001 << w_idx_d;
            end
            StRelease: w_grant_d = 4'b0001 << w_idx_d;
            StClear: begin
                w_wren_d = 1'b1;
                w_addr_d = ADDR_WIDTH'(w_cnt_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge SC_REGBANK_ARBITER_CLOCK_50 or negedge SC_REGBANK_ARBITER_RESET_InLow) begin
        if (!SC_REGBANK_ARBITER_RESET_InLow) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_wren  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_grant <= 4'b0000;
            r_ack   <= 4'b0000;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_idx   <= w_idx_d;
            r_cnt   <= w_cnt_d;
            r_pend  <= w_pend_d;
            r_wren  <= w_wren_d;
            r_addr  <= w_addr_d;
            r_data  <= w_data_d;
            r_grant <= w_grant_d;
            r_ack   <= w_ack_d;
            r_busy  <= w_busy_d;
        end
    end

    assign SC_REGBANK_ARBITER_wren_Out     = r_wren;
    assign SC_REGBANK_ARBITER_addr_OutBUS  = r_addr;
    assign SC_REGBANK_ARBITER_data_OutBUS  = r_data;
    assign SC_REGBANK_ARBITER_grant_OutBUS = r_grant;
    assign SC_REGBANK_ARBITER_ack_OutBUS   = r_ack;
    assign SC_REGBANK_ARBITER_busy_Out     = r_busy;

endmodule

// File: tb/tb_sc_regbank_arbiter.sv
// Bench for sc_regbank_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model that schedules expected output beats in a queue.
module tb_sc_regbank_arbiter;

    localparam int DW = 4;
    localparam int AW = 3;
    localparam int NR = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [3:0]      req = 4'b0000;
    logic [4*AW-1:0] addr_in = '0;
    logic [4*DW-1:0] data_in = '0;
    logic            clr = 1'b0;
    logic            wren;
    logic [AW-1:0]   addr_o;
    logic [DW-1:0]   data_o;
    logic [3:0]      grant;
    logic [3:0]      ack;
    logic            busy;

    sc_regbank_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NREGS      (NR)
    ) dut (
        .SC_REGBANK_ARBITER_CLOCK_50     (clk),
        .SC_REGBANK_ARBITER_RESET_InLow  (rst_n),
        .SC_REGBANK_ARBITER_req_InBUS    (req),
        .SC_REGBANK_ARBITER_addr_InBUS   (addr_in),
        .SC_REGBANK_ARBITER_data_InBUS   (data_in),
        .SC_REGBANK_ARBITER_clear_InHigh (clr),
        .SC_REGBANK_ARBITER_wren_Out     (wren),
        .SC_REGBANK_ARBITER_addr_OutBUS  (addr_o),
        .SC_REGBANK_ARBITER_data_OutBUS  (data_o),
        .SC_REGBANK_ARBITER_grant_OutBUS (grant),
        .SC_REGBANK_ARBITER_ack_OutBUS   (ack),
        .SC_REGBANK_ARBITER_busy_Out     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wren;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    grant;
        logic [3:0]    ack;
        logic          busy;
    } beat_t;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t exp_q[$];
    beat_t m_exp;
    int    m_owner;
    int    m_ptr;
    bit    m_pend;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t obs();
        beat_t b;
        b.wren  = wren;
        b.addr  = addr_o;
        b.data  = data_o;
        b.grant = grant;
        b.ack   = ack;
        b.busy  = busy;
        return b;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_owner = -1;
        m_ptr   = 0;
        m_pend  = 0;
        m_exp   = '0;
    endtask

    // One clock edge of the reference: pop a scheduled beat, or decide what happens next.
    task automatic model_step();
        beat_t b;
        beat_t t;
        int    w;
        b = '0;
        if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
        end else if (m_owner >= 0) begin
            if (req[m_owner]) begin
                b.grant = 4'(1 << m_owner);
                b.busy  = 1'b1;
            end else begin
                m_owner = -1;
            end
        end else if (m_pend) begin
            m_pend = 0;
            for (int a = 0; a < NR; a++) begin
                t      = '0;
                t.wren = 1'b1;
                t.addr = AW'(a);
                t.busy = 1'b1;
                exp_q.push_back(t);
            end
            t = '0;
            exp_q.push_back(t);
            b = exp_q.pop_front();
        end else if (req != 4'b0000) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            t       = '0;
            t.grant = 4'(1 << w);
            t.busy  = 1'b1;
            t.wren  = 1'b1;
            t.addr  = addr_in[w*AW +: AW];
            t.data  = data_in[w*DW +: DW];
            exp_q.push_back(t);
            t.wren = 1'b0;
            t.addr = '0;
            t.data = '0;
            t.ack  = t.grant;
            exp_q.push_back(t);
            t.ack = 4'b0000;
            exp_q.push_back(t);
            b       = exp_q.pop_front();
            m_owner = w;
            m_ptr   = (w + 1) % 4;
        end
        if (clr) m_pend = 1;
        m_exp = b;
    endtask

    // Advance one cycle, check every output against the model, return at the falling edge.
    task automatic cyc();
        beat_t o;
        @(posedge clk);
        model_step();
        #1;
        o = obs();
        if (!m_exp.wren) begin
            o.addr = '0;
            o.data = '0;
        end
        check_eq("beat", 32'(o), 32'(m_exp));
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        req   = 4'b0000;
        clr   = 1'b0;
        #1;
        check_eq("rst_outputs", 32'(obs()), 32'd0);
        model_reset();
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_out(input int n);
        req = 4'b0000;
        clr = 1'b0;
        repeat (n) cyc();
    endtask

    // Requesters drop on ack; those in rereq raise again two cycles after dropping.
    task automatic run_order(input string tag, input logic [3:0] start, input logic [3:0] rereq,
                             input logic [15:0] order);
        int got_n;
        int cool[4];
        got_n = 0;
        cool  = '{default: 0};
        addr_in = 12'($urandom);
        data_in = 16'($urandom);
        req = start;
        for (int c = 0; c < 80 && got_n < 4; c++) begin
            cyc();
            if (wren && grant != 4'b0000) begin
                check_eq(tag, 32'(grant), 32'(order[got_n*4 +: 4]));
                got_n++;
            end
            for (int i = 0; i < 4; i++) begin
                if (m_exp.ack[i]) begin
                    req[i] = 1'b0;
                    if (rereq[i]) cool[i] = 2;
                end else if (cool[i] > 0) begin
                    cool[i]--;
                    if (cool[i] == 0) req[i] = 1'b1;
                end
            end
        end
        check_eq({tag, "_count"}, 32'(got_n), 32'd4);
        idle_out(6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sweep_n;
        bit   found;
        logic [3:0] own;
        int   hold[4];
        bit   acked[4];

        model_reset();
        @(negedge clk);
        do_reset(3);

        // Single request from requester 2.
        addr_in = '0;
        data_in = '0;
        addr_in[2*AW +: AW] = 3'd5;
        data_in[2*DW +: DW] = 4'hA;
        req = 4'b0100;
        cyc();
        check_eq("t1_write", {wren, addr_o, data_o, grant}, {1'b1, 3'd5, 4'hA, 4'b0100});
        cyc();
        check_eq("t1_ack", 32'(ack), 32'(4'b0100));
        req = 4'b0000;
        cyc();
        cyc();
        check_eq("t1_idle_busy", 32'(busy), 32'd0);
        idle_out(3);

        do_reset(2);
        run_order("t2_order", 4'b1111, 4'b0000, 16'b1000_0100_0010_0001);
        run_order("t3_alt", 4'b1001, 4'b1001, 16'b1000_0001_1000_0001);

        // Clear pulse during requester 1's write; requester 2 waits behind the sweep.
        addr_in = 12'($urandom);
        data_in = 16'($urandom);
        req = 4'b0110;
        cyc();
        check_eq("t4_first", 32'(grant), 32'(4'b0010));
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        req[1] = 1'b0;
        sweep_n = 0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            cyc();
            if (wren && grant == 4'b0000) begin
                check_eq("t4_sweep", {addr_o, data_o, busy}, {AW'(sweep_n), 4'h0, 1'b1});
                sweep_n++;
            end else if (wren) begin
                check_eq("t4_next", 32'(grant), 32'(4'b0100));
                found = 1;
            end
        end
        check_eq("t4_sweep_count", 32'(sweep_n), 32'd8);
        check_eq("t4_found", 32'(found), 32'd1);
        idle_out(6);

        // Reset while the sweep is at address 3.
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            cyc();
            if (wren && addr_o == 3'd3) found = 1;
        end
        check_eq("t5_reach3", 32'(found), 32'd1);
        do_reset(2);
        idle_out(12);
        req = 4'b1111;
        cyc();
        check_eq("t5_ptr", 32'(grant), 32'(4'b0001));
        idle_out(6);

        // Owner holds its request for 5 cycles after ack while another waits.
        req = 4'b0011;
        own = 4'b0000;
        for (int c = 0; c < 10 && own == 4'b0000; c++) begin
            cyc();
            own = m_exp.ack;
        end
        check_eq("t6_acked", 32'(own != 4'b0000), 32'd1);
        for (int c = 0; c < 5; c++) begin
            cyc();
            check_eq("t6_hold", {wren, grant}, {1'b0, own});
        end
        req = req & ~own;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            cyc();
            if (wren) begin
                check_eq("t6_next", 32'(grant), 32'(req));
                found = 1;
            end
        end
        check_eq("t6_found", 32'(found), 32'd1);
        idle_out(6);

        // Random traffic.
        hold  = '{default: 0};
        acked = '{default: 0};
        for (int c = 0; c < 3000; c++) begin
            cyc();
            clr = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < 4; i++) begin
                if (m_exp.ack[i]) begin
                    acked[i] = 1;
                    hold[i]  = $urandom_range(0, 3);
                end
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        acked[i] = 0;
                        addr_in[i*AW +: AW] = AW'($urandom);
                        data_in[i*DW +: DW] = DW'($urandom);
                    end
                end else if (acked[i]) begin
                    if (hold[i] == 0) req[i] = 1'b0;
                    else hold[i]--;
                end else if ($urandom_range(0, 49) == 0) begin
                    req[i] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    data_in[i*DW +: DW] = DW'($urandom);
                end
            end
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1);
                acked = '{default: 0};
            end
        end
        idle_out(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
